// File: rtl/mwr_pkg.sv
// Shared constants and helpers for the multi-writer register and its arbiter.
package mwr_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Round-robin pointer width; a single bit even when NW would need fewer.
    function automatic int ptr_width(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/multi_writer_reg_if.sv
// Write-port bundle and registered status of one multi-writer register.
interface multi_writer_reg_if #(
    parameter int NW = 3,
    parameter int W  = 8,
    parameter int CW = 8
);

    logic              clr;
    logic              cnt_clr;
    logic [NW-1:0]     wr_en;
    logic [NW*W-1:0]   wr_data;
    logic [W-1:0]      q;
    logic [NW-1:0]     grant;
    logic              conflict;
    logic              conflict_mismatch;
    logic [CW-1:0]     conflict_cnt;

    modport master (
        output clr, cnt_clr, wr_en, wr_data,
        input  q, grant, conflict, conflict_mismatch, conflict_cnt
    );

    modport slave (
        input  clr, cnt_clr, wr_en, wr_data,
        output q, grant, conflict, conflict_mismatch, conflict_cnt
    );

endinterface

// File: rtl/mwr_arb.sv
// Single-cycle arbiter: fixed priority from index 0, or round-robin from ptr.
module mwr_arb
    import mwr_pkg::*;
#(
    parameter  int NW   = 3,
    parameter  int MODE = MODE_FIXED,
    localparam int PW   = ptr_width(NW)
) (
    input  logic [NW-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NW-1:0] gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [PW-1:0] start;
    logic          found;
    int            idx;

    assign start = (MODE == MODE_RR) ? ptr : '0;
    assign any   = |req;

    // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NW; off++) begin
            idx = (int'(start) + off) % NW;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/multi_writer_reg.sv
// One register shared by NW writers, with deterministic arbitration and conflict tracking.
module multi_writer_reg
    import mwr_pkg::*;
#(
    parameter int           NW      = 3,
    parameter int           W       = 8,
    parameter int           MODE    = MODE_FIXED,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter int           CW      = 8
) (
    input logic               clk,
    input logic               rst_n,
    multi_writer_reg_if.slave bus
);

    localparam int PW = ptr_width(NW);

    logic [PW-1:0] ptr, gnt_idx;
    logic [NW-1:0] gnt;
    logic          any, multi, diff, mm_next;
    logic [W-1:0]  win_data;

    logic [W-1:0]  q_r;
    logic [NW-1:0] grant_r;
    logic          conflict_r, mismatch_r;
    logic [CW-1:0] cnt_r;

    mwr_arb #(.NW(NW), .MODE(MODE)) u_arb (
        .req    (bus.wr_en),
        .ptr    (ptr),
        .gnt    (gnt),
        .gnt_idx(gnt_idx),
        .any    (any)
    );

    // A mismatch is any requester whose data differs from what actually lands in q.
    always_comb begin
        win_data = bus.wr_data[int'(gnt_idx)*W +: W];
        multi    = (bus.wr_en & (bus.wr_en - NW'(1))) != '0;
        diff     = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (bus.wr_en[i] && (bus.wr_data[i*W +: W] != win_data)) diff = 1'b1;
        end
        mm_next = !bus.clr && multi && diff;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r        <= RST_VAL;
            grant_r    <= '0;
            conflict_r <= 1'b0;
            mismatch_r <= 1'b0;
            ptr        <= '0;
        end else if (bus.clr) begin
            q_r        <= RST_VAL;
            grant_r    <= '0;
            conflict_r <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            grant_r    <= gnt;
            conflict_r <= multi;
            mismatch_r <= mm_next;
            if (any) q_r <= win_data;
            if (MODE == MODE_RR && any) begin
                ptr <= (gnt_idx == PW'(NW - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Counter advances on the same edge that raises conflict_mismatch; cnt_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (bus.cnt_clr) begin
            cnt_r <= '0;
        end else if (mm_next && (cnt_r != '1)) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign bus.q                 = q_r;
    assign bus.grant             = grant_r;
    assign bus.conflict          = conflict_r;
    assign bus.conflict_mismatch = mismatch_r;
    assign bus.conflict_cnt      = cnt_r;

endmodule
